// File: rtl/frame_sched_pkg.sv
// Shared types and defaults for the frame-buffer scheduler.
// Latency: n/a (types, constants and a pure address function only).
// Backpressure: n/a.
package frame_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        XFER = 2'd2,
        ERR  = 2'd3
    } state_e;

    localparam logic [63:0] DEF_BASE_ADDR   = 64'h4000_0000;
    localparam logic [63:0] DEF_BUF_STRIDE  = 64'h2000_0000;
    localparam logic [63:0] DEF_FRAME_BYTES = 64'd1310720;    // 1280 * 1024
    localparam int          DEF_TIMEOUT_CYC = 4000000;

    // DDR byte address of a slot: base + idx * stride.
    function automatic logic [63:0] slot_addr(input logic [63:0] base,
                                              input logic [63:0] stride,
                                              input logic [2:0]  idx);
        return base + stride * {61'd0, idx};
    endfunction

endpackage

// File: rtl/frame_buf_sched_sync.sv
// 2-FF synchronizer plus rising-edge detect for an asynchronous level or pulse.
// Latency: pulse_o rises 3 clocks after async_i rises; one pulse per rising edge.
// Backpressure: none; a level held high yields exactly one pulse.
// Ports: clk_i/rst_ni clock and async active-low reset, async_i raw input,
//        pulse_o one-cycle registered pulse in the clk_i domain.
module pulse_sync_rise (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic pulse_o
);

    (* ASYNC_REG = "TRUE" *) logic meta_q;
    (* ASYNC_REG = "TRUE" *) logic sync_q;
    logic prev_q;
    logic pulse_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            meta_q  <= async_i;
            sync_q  <= meta_q;
            prev_q  <= sync_q;
            pulse_q <= sync_q & ~prev_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/frame_buf_sched.sv
// N-slot DDR frame-buffer scheduler for the S2MM mover: one command per accepted frame.
// Latency: start is combinational on the accepted frame_sof; done_vld 3 clocks after mover_finish rises.
// Backpressure: a frame whose target slot is still owned by software is dropped whole and counted.
// Ports: AXIS_CLK/AXIS_RSTN clock and async active-low reset; enable, frame_sof, frame_eof
//        stream framing; mover_finish async mover done; release_vld/release_idx software
//        slot return; frame_gate, start, ddr_address, data_size mover side; done_vld/done_idx,
//        full_mask, drop_cnt, err status.
// Optional: define FRAME_TIMEOUT_EN to enable the mover watchdog (TIMEOUT_CYC clocks in XFER).
module frame_buf_sched
    import frame_sched_pkg::*;
#(
    parameter int          NUM_BUF     = 4,
    parameter logic [63:0] BASE_ADDR   = DEF_BASE_ADDR,
    parameter logic [63:0] BUF_STRIDE  = DEF_BUF_STRIDE,
    parameter logic [63:0] FRAME_BYTES = DEF_FRAME_BYTES,
    parameter int          TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic               AXIS_CLK,
    input  logic               AXIS_RSTN,
    input  logic               enable,
    input  logic               frame_sof,
    input  logic               frame_eof,
    input  logic               mover_finish,
    input  logic               release_vld,
    input  logic [2:0]         release_idx,
    output logic               frame_gate,
    output logic               start,
    output logic [63:0]        ddr_address,
    output logic [63:0]        data_size,
    output logic               done_vld,
    output logic [2:0]         done_idx,
    output logic [NUM_BUF-1:0] full_mask,
    output logic [15:0]        drop_cnt,
    output logic               err
);

    state_e             state_q, state_d;
    logic [2:0]         wr_ptr_q, wr_ptr_d;
    logic [NUM_BUF-1:0] full_q, full_d;
    logic               gate_q, gate_d;
    logic [15:0]        drop_q, drop_d;
    logic               err_q, err_d;
    logic [63:0]        addr_q;
    logic               fin_pos;
    logic               slot_full;
    logic               timeout_hit;

    pulse_sync_rise u_fin_sync (
        .clk_i   (AXIS_CLK),
        .rst_ni  (AXIS_RSTN),
        .async_i (mover_finish),
        .pulse_o (fin_pos)
    );

    always_comb begin
        slot_full = 1'b0;
        for (int i = 0; i < NUM_BUF; i++) begin
            if (wr_ptr_q == 3'(i)) slot_full = full_q[i];
        end
    end

`ifdef FRAME_TIMEOUT_EN
    logic [31:0] tmo_q, tmo_d;

    // Counts XFER cycles; restarts from zero every time XFER is entered.
    always_comb begin
        tmo_d       = (state_q == XFER) ? tmo_q + 32'd1 : 32'd0;
        timeout_hit = (state_q == XFER) && (tmo_q == 32'(TIMEOUT_CYC - 1)) && !fin_pos;
    end

    always_ff @(posedge AXIS_CLK or negedge AXIS_RSTN) begin
        if (!AXIS_RSTN) tmo_q <= 32'd0;
        else            tmo_q <= tmo_d;
    end
`else
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = ^TIMEOUT_CYC;
    assign timeout_hit        = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        full_d   = full_q;
        gate_d   = gate_q;
        drop_d   = drop_q;
        err_d    = err_q;
        start    = 1'b0;
        done_vld = 1'b0;

        // Release first so a completion on the same slot overrides it below.
        // Indices at or beyond NUM_BUF match no slot and are ignored.
        if (release_vld) begin
            for (int i = 0; i < NUM_BUF; i++) begin
                if (release_idx == 3'(i)) full_d[i] = 1'b0;
            end
        end

        // The gate follows the stream, not the mover: it closes after tlast
        // even when the mover already reported done earlier.
        if (frame_eof) gate_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) state_d = ARM;
            end
            ARM: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (frame_sof) begin
                    if (!slot_full) begin
                        start   = 1'b1;
                        gate_d  = ~frame_eof;
                        state_d = XFER;
                    end else if (drop_q != 16'hFFFF) begin
                        drop_d = drop_q + 16'd1;
                    end
                end
            end
            XFER: begin
                if (fin_pos) begin
                    done_vld = 1'b1;
                    for (int i = 0; i < NUM_BUF; i++) begin
                        if (wr_ptr_q == 3'(i)) full_d[i] = 1'b1;
                    end
                    wr_ptr_d = (wr_ptr_q == 3'(NUM_BUF - 1)) ? 3'd0 : wr_ptr_q + 3'd1;
                    state_d  = enable ? ARM : IDLE;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    gate_d  = 1'b0;
                    state_d = ERR;
                end
            end
            ERR: begin
                gate_d = 1'b0;
                if (!enable) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge AXIS_CLK or negedge AXIS_RSTN) begin
        if (!AXIS_RSTN) begin
            state_q  <= IDLE;
            wr_ptr_q <= 3'd0;
            full_q   <= '0;
            gate_q   <= 1'b0;
            drop_q   <= 16'd0;
            err_q    <= 1'b0;
            addr_q   <= BASE_ADDR;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            full_q   <= full_d;
            gate_q   <= gate_d;
            drop_q   <= drop_d;
            err_q    <= err_d;
            // Tracks the next pointer so the address is stable before start.
            addr_q   <= slot_addr(BASE_ADDR, BUF_STRIDE, wr_ptr_d);
        end
    end

    // start covers the sof beat itself, gate_q covers the rest of the frame.
    assign frame_gate  = gate_q | start;
    assign ddr_address = addr_q;
    assign data_size   = FRAME_BYTES;
    assign done_idx    = wr_ptr_q;
    assign full_mask   = full_q;
    assign drop_cnt    = drop_q;
    assign err         = err_q;

endmodule

// File: tb/tb_frame_buf_sched.sv
// Directed bench for frame_buf_sched (NUM_BUF=4, TIMEOUT_CYC=1000).
// Latency: n/a.
// Backpressure: n/a.
module tb_frame_buf_sched;

    logic        AXIS_CLK = 1'b0;
    logic        AXIS_RSTN = 1'b1;
    logic        enable = 1'b0;
    logic        frame_sof = 1'b0;
    logic        frame_eof = 1'b0;
    logic        mover_finish = 1'b0;
    logic        release_vld = 1'b0;
    logic [2:0]  release_idx = 3'd0;
    logic        frame_gate;
    logic        start;
    logic [63:0] ddr_address;
    logic [63:0] data_size;
    logic        done_vld;
    logic [2:0]  done_idx;
    logic [3:0]  full_mask;
    logic [15:0] drop_cnt;
    logic        err;

    int checks   = 0;
    int failures = 0;

    frame_buf_sched #(.NUM_BUF(4), .TIMEOUT_CYC(1000)) dut (
        .AXIS_CLK     (AXIS_CLK),
        .AXIS_RSTN    (AXIS_RSTN),
        .enable       (enable),
        .frame_sof    (frame_sof),
        .frame_eof    (frame_eof),
        .mover_finish (mover_finish),
        .release_vld  (release_vld),
        .release_idx  (release_idx),
        .frame_gate   (frame_gate),
        .start        (start),
        .ddr_address  (ddr_address),
        .data_size    (data_size),
        .done_vld     (done_vld),
        .done_idx     (done_idx),
        .full_mask    (full_mask),
        .drop_cnt     (drop_cnt),
        .err          (err)
    );

    always #5 AXIS_CLK = ~AXIS_CLK;

    task automatic tick();
        @(posedge AXIS_CLK);
        #1;
    endtask

    task automatic send_sof(output logic s, output logic [63:0] a, output logic g);
        frame_sof = 1'b1;
        #1;
        s = start;
        a = ddr_address;
        g = frame_gate;
        tick();
        frame_sof = 1'b0;
    endtask

    task automatic send_eof();
        tick();
        frame_eof = 1'b1;
        tick();
        frame_eof = 1'b0;
    endtask

    task automatic release_slot(input logic [2:0] idx);
        release_vld = 1'b1;
        release_idx = idx;
        tick();
        release_vld = 1'b0;
    endtask

    // Single-cycle finish pulse; returns clocks until done_vld (0 = never seen).
    task automatic run_finish(output int lat, output logic [2:0] idx);
        mover_finish = 1'b1;
        lat = 0;
        idx = 3'd7;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 1) mover_finish = 1'b0;
            #1;
            if (done_vld) begin
                lat = k;
                idx = done_idx;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2 AXIS_RSTN = 1'b0;
        #1;
        checks++; if (start !== 1'b0) begin failures++; $display("FAIL reset_start: got %b want 0", start); end
        checks++; if (frame_gate !== 1'b0) begin failures++; $display("FAIL reset_gate: got %b want 0", frame_gate); end
        checks++; if (ddr_address !== 64'h4000_0000) begin failures++; $display("FAIL reset_addr: got %h want 40000000", ddr_address); end
        checks++; if (data_size !== 64'd1310720) begin failures++; $display("FAIL reset_size: got %0d want 1310720", data_size); end
        checks++; if (done_vld !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done_vld); end
        checks++; if (full_mask !== 4'h0) begin failures++; $display("FAIL reset_mask: got %h want 0", full_mask); end
        checks++; if (drop_cnt !== 16'd0) begin failures++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", err); end
        @(negedge AXIS_CLK);
        AXIS_RSTN = 1'b1;
        enable = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_ring_fill();
        logic s, g;
        logic [63:0] a, exp_a;
        logic [2:0] idx;
        int lat;
        for (int i = 0; i < 4; i++) begin
            exp_a = 64'h4000_0000 + 64'(i) * 64'h2000_0000;
            send_sof(s, a, g);
            checks++; if (s !== 1'b1) begin failures++; $display("FAIL ring_start[%0d]: got %b want 1", i, s); end
            checks++; if (a !== exp_a) begin failures++; $display("FAIL ring_addr[%0d]: got %h want %h", i, a, exp_a); end
            checks++; if (g !== 1'b1) begin failures++; $display("FAIL ring_gate_sof[%0d]: got %b want 1", i, g); end
            checks++; if (frame_gate !== 1'b1) begin failures++; $display("FAIL ring_gate_mid[%0d]: got %b want 1", i, frame_gate); end
            send_eof();
            checks++; if (frame_gate !== 1'b0) begin failures++; $display("FAIL ring_gate_eof[%0d]: got %b want 0", i, frame_gate); end
            run_finish(lat, idx);
            checks++; if (lat !== 3) begin failures++; $display("FAIL ring_latency[%0d]: got %0d want 3", i, lat); end
            checks++; if (idx !== 3'(i)) begin failures++; $display("FAIL ring_done_idx[%0d]: got %0d want %0d", i, idx, i); end
            tick();
        end
        checks++; if (full_mask !== 4'hF) begin failures++; $display("FAIL ring_mask: got %h want f", full_mask); end
    endtask

    task automatic test_overflow();
        logic s, g;
        logic [63:0] a;
        logic [2:0] idx;
        int lat;
        for (int i = 0; i < 2; i++) begin
            send_sof(s, a, g);
            checks++; if (s !== 1'b0) begin failures++; $display("FAIL ovf_start[%0d]: got %b want 0", i, s); end
            checks++; if (g !== 1'b0) begin failures++; $display("FAIL ovf_gate[%0d]: got %b want 0", i, g); end
            tick();
        end
        checks++; if (drop_cnt !== 16'd2) begin failures++; $display("FAIL ovf_drop: got %0d want 2", drop_cnt); end
        release_slot(3'd5);
        checks++; if (full_mask !== 4'hF) begin failures++; $display("FAIL ovf_release_oor: got %h want f", full_mask); end
        release_slot(3'd0);
        checks++; if (full_mask !== 4'hE) begin failures++; $display("FAIL ovf_release0: got %h want e", full_mask); end
        send_sof(s, a, g);
        checks++; if (s !== 1'b1) begin failures++; $display("FAIL ovf_restart: got %b want 1", s); end
        checks++; if (a !== 64'h4000_0000) begin failures++; $display("FAIL ovf_restart_addr: got %h want 40000000", a); end
        send_eof();
        run_finish(lat, idx);
        checks++; if (idx !== 3'd0) begin failures++; $display("FAIL ovf_done_idx: got %0d want 0", idx); end
        tick();
    endtask

    task automatic test_simultaneous();
        logic s, g;
        logic [63:0] a;
        logic [2:0] idx;
        int lat;
        release_slot(3'd1);
        send_sof(s, a, g);
        checks++; if (a !== 64'h6000_0000) begin failures++; $display("FAIL sim_addr: got %h want 60000000", a); end
        send_sof(s, a, g);
        checks++; if (s !== 1'b0) begin failures++; $display("FAIL sim_sof_in_xfer: got %b want 0", s); end
        checks++; if (drop_cnt !== 16'd2) begin failures++; $display("FAIL sim_no_drop: got %0d want 2", drop_cnt); end
        send_eof();
        run_finish(lat, idx);
        checks++; if (idx !== 3'd1) begin failures++; $display("FAIL sim_done_idx: got %0d want 1", idx); end
        release_slot(3'd1);
        checks++; if (full_mask !== 4'hF) begin failures++; $display("FAIL sim_set_wins: got %h want f", full_mask); end
    endtask

    task automatic test_finish_before_eof();
        logic s, g;
        logic [63:0] a;
        logic [2:0] idx;
        int lat;
        release_slot(3'd2);
        send_sof(s, a, g);
        checks++; if (a !== 64'h8000_0000) begin failures++; $display("FAIL early_addr: got %h want 80000000", a); end
        tick();
        run_finish(lat, idx);
        checks++; if (lat !== 3) begin failures++; $display("FAIL early_latency: got %0d want 3", lat); end
        checks++; if (idx !== 3'd2) begin failures++; $display("FAIL early_done_idx: got %0d want 2", idx); end
        tick();
        checks++; if (frame_gate !== 1'b1) begin failures++; $display("FAIL early_gate_open: got %b want 1", frame_gate); end
        frame_eof = 1'b1;
        tick();
        frame_eof = 1'b0;
        checks++; if (frame_gate !== 1'b0) begin failures++; $display("FAIL early_gate_close: got %b want 0", frame_gate); end
        checks++; if (full_mask !== 4'hF) begin failures++; $display("FAIL early_mask: got %h want f", full_mask); end
    endtask

    task automatic test_level_finish();
        logic s, g;
        logic [63:0] a;
        int cnt;
        release_slot(3'd3);
        send_sof(s, a, g);
        checks++; if (a !== 64'hA000_0000) begin failures++; $display("FAIL level_addr: got %h want a0000000", a); end
        send_eof();
        mover_finish = 1'b1;
        cnt = 0;
        repeat (100) begin
            tick();
            if (done_vld === 1'b1) cnt++;
        end
        mover_finish = 1'b0;
        repeat (10) begin
            tick();
            if (done_vld === 1'b1) cnt++;
        end
        checks++; if (cnt !== 1) begin failures++; $display("FAIL level_done_count: got %0d want 1", cnt); end
        checks++; if (ddr_address !== 64'h4000_0000) begin failures++; $display("FAIL level_wrap_addr: got %h want 40000000", ddr_address); end
        checks++; if (full_mask !== 4'hF) begin failures++; $display("FAIL level_mask: got %h want f", full_mask); end
    endtask

`ifdef FRAME_TIMEOUT_EN
    task automatic test_timeout();
        logic s, g, seen;
        logic [63:0] a;
        logic [2:0] idx;
        int k, lat;
        release_slot(3'd0);
        send_sof(s, a, g);
        checks++; if (s !== 1'b1) begin failures++; $display("FAIL tmo_start: got %b want 1", s); end
        k = 0;
        seen = 1'b0;
        while (k < 1100 && err !== 1'b1) begin
            tick();
            k++;
            frame_eof = (k == 2);
            if (done_vld === 1'b1) seen = 1'b1;
        end
        frame_eof = 1'b0;
        checks++; if (k !== 1000) begin failures++; $display("FAIL tmo_cycle: got %0d want 1000", k); end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL tmo_no_done: got %b want 0", seen); end
        checks++; if (ddr_address !== 64'h4000_0000) begin failures++; $display("FAIL tmo_ptr_kept: got %h want 40000000", ddr_address); end
        send_sof(s, a, g);
        checks++; if (s !== 1'b0 || g !== 1'b0) begin failures++; $display("FAIL tmo_err_sof: got start=%b gate=%b want 0 0", s, g); end
        enable = 1'b0;
        tick();
        tick();
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL tmo_err_sticky: got %b want 1", err); end
        enable = 1'b1;
        tick();
        send_sof(s, a, g);
        checks++; if (s !== 1'b1 || a !== 64'h4000_0000) begin failures++; $display("FAIL tmo_recover: got start=%b addr=%h want 1 40000000", s, a); end
        send_eof();
        run_finish(lat, idx);
        checks++; if (idx !== 3'd0) begin failures++; $display("FAIL tmo_recover_idx: got %0d want 0", idx); end
        tick();
    endtask
`endif

    task automatic test_reset_mid_xfer();
        logic s, g;
        logic [63:0] a;
        int cnt;
        release_slot(3'd0);
        send_sof(s, a, g);
        checks++; if (frame_gate !== 1'b1) begin failures++; $display("FAIL rst_pre_gate: got %b want 1", frame_gate); end
        #3 AXIS_RSTN = 1'b0;
        #1;
        checks++; if (frame_gate !== 1'b0) begin failures++; $display("FAIL rst_gate: got %b want 0", frame_gate); end
        checks++; if (full_mask !== 4'h0) begin failures++; $display("FAIL rst_mask: got %h want 0", full_mask); end
        checks++; if (ddr_address !== 64'h4000_0000) begin failures++; $display("FAIL rst_addr: got %h want 40000000", ddr_address); end
        checks++; if (drop_cnt !== 16'd0) begin failures++; $display("FAIL rst_drop: got %0d want 0", drop_cnt); end
        @(negedge AXIS_CLK);
        AXIS_RSTN = 1'b1;
        tick();
        tick();
        mover_finish = 1'b1;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (k == 0) mover_finish = 1'b0;
            if (done_vld === 1'b1) cnt++;
        end
        checks++; if (cnt !== 0) begin failures++; $display("FAIL rst_stray_finish: got %0d done pulses want 0", cnt); end
    endtask

    initial begin
        test_reset();
        test_ring_fill();
        test_overflow();
        test_simultaneous();
        test_finish_before_eof();
        test_level_finish();
`ifdef FRAME_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_xfer();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
